generic_pidtovid: RTL and testbench

- Physical-to-virtual hart ID translator; the inverse of the VID-to-PID mapping used by per-hart debug and trace routing.
- A fuse/VID map is loaded and scanned sequentially to build a registered inverse table (owner PID per VID), with duplicate-VID detection.
- Translation requests (scalar PID plus PID-indexed bit vector) are then served through a valid/ready handshake with a registered, single-entry response stage.

---
 rtl/generic_pidtovid.sv | 154 +++++++++++++++
 tb/tb_generic_pidtovid.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_pidtovid.sv
// Physical-to-virtual hart ID translator: scans a loaded VID map into an owner-per-VID table, then translates requests.
// Response latency 1 cycle; req_ready drops while a response is stalled or the table is being (re)built.
module generic_pidtovid #(
  parameter int NumHarts    = 8,
  parameter int NumHartsIdx = (NumHarts == 1) ? 1 : $clog2(NumHarts)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cfg_load,
  input  logic [NumHarts-1:0]             cfg_fuse_map,
  input  logic [NumHarts*NumHartsIdx-1:0] cfg_vid_map,
  output logic                            cfg_done,
  output logic                            map_err,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [NumHartsIdx-1:0]          req_pid,
  input  logic [NumHarts-1:0]             req_pid_vector,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [NumHartsIdx-1:0]          rsp_vid,
  output logic                            rsp_mapped,
  output logic [NumHarts-1:0]             rsp_vid_vector
);

  // Tables are padded to the full ID space so any PID/VID code indexes safely.
  localparam int NumIds = 1 << NumHartsIdx;

  typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NumHarts-1:0]    r_fuse;
  logic [NumHartsIdx-1:0] r_vid [NumHarts];
  logic [NumHartsIdx-1:0] r_owner [NumIds];
  logic [NumIds-1:0]      r_owner_vld;
  logic [NumHartsIdx-1:0] r_idx;
  logic                   r_map_err;
  logic                   r_done_pend;
  logic                   r_cfg_done;
  logic                   r_rsp_valid;
  logic                   r_rsp_mapped;
  logic [NumHartsIdx-1:0] r_rsp_vid;
  logic [NumHarts-1:0]    r_rsp_vid_vector;

  logic                   w_scan_last;
  logic [NumHartsIdx-1:0] w_scan_vid;
  logic                   w_accept;
  logic [NumIds-1:0]      w_fuse_ext;
  logic [NumHartsIdx-1:0] w_pid_vid;
  logic                   w_rsp_mapped;
  logic [NumHartsIdx-1:0] w_rsp_vid;
  logic [NumHarts-1:0]    w_rsp_vid_vector;

  assign w_scan_last = (r_idx == NumHartsIdx'(NumHarts - 1));
  assign w_scan_vid  = r_vid[r_idx];
  assign req_ready   = (r_state == READY) & ~cfg_load & (~r_rsp_valid | rsp_ready);
  assign w_accept    = req_valid & req_ready;
  assign w_fuse_ext  = NumIds'(r_fuse);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cfg_load) begin
      w_state_nxt = SCAN;
    end else begin
      case (r_state)
        SCAN:    if (w_scan_last) w_state_nxt = READY;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Out-of-range PIDs find no VID entry and no fuse bit, so they come back unmapped.
  always_comb begin
    w_pid_vid = '0;
    for (int p = 0; p < NumHarts; p++) begin
      if (req_pid == NumHartsIdx'(p)) w_pid_vid = r_vid[p];
    end
  end

  assign w_rsp_mapped = w_fuse_ext[req_pid] & r_owner_vld[w_pid_vid] &
                        (r_owner[w_pid_vid] == req_pid);
  assign w_rsp_vid    = w_rsp_mapped ? w_pid_vid : '0;

  always_comb begin
    w_rsp_vid_vector = '0;
    for (int v = 0; v < NumHarts; v++) begin
      w_rsp_vid_vector[v] = r_owner_vld[v] & req_pid_vector[r_owner[v]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fuse      <= '0;
      r_owner_vld <= '0;
      r_idx       <= '0;
      r_map_err   <= 1'b0;
      r_done_pend <= 1'b0;
      r_cfg_done  <= 1'b0;
      for (int p = 0; p < NumHarts; p++) r_vid[p] <= '0;
      for (int v = 0; v < NumIds; v++) r_owner[v] <= '0;
    end else begin
      r_cfg_done  <= r_done_pend & ~cfg_load;
      r_done_pend <= 1'b0;
      if (cfg_load) begin
        r_fuse      <= cfg_fuse_map;
        r_owner_vld <= '0;
        r_idx       <= '0;
        r_map_err   <= 1'b0;
        for (int p = 0; p < NumHarts; p++) r_vid[p] <= cfg_vid_map[p*NumHartsIdx +: NumHartsIdx];
        for (int v = 0; v < NumIds; v++) r_owner[v] <= '0;
      end else if (r_state == SCAN) begin
        // Lowest PID keeps a contested VID; later claimants only raise the error.
        if (r_fuse[r_idx]) begin
          if (r_owner_vld[w_scan_vid]) begin
            r_map_err <= 1'b1;
          end else begin
            r_owner_vld[w_scan_vid] <= 1'b1;
            r_owner[w_scan_vid]     <= r_idx;
          end
        end
        r_idx       <= w_scan_last ? '0 : r_idx + 1'b1;
        r_done_pend <= w_scan_last;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid      <= 1'b0;
      r_rsp_mapped     <= 1'b0;
      r_rsp_vid        <= '0;
      r_rsp_vid_vector <= '0;
    end else if (w_accept) begin
      r_rsp_valid      <= 1'b1;
      r_rsp_mapped     <= w_rsp_mapped;
      r_rsp_vid        <= w_rsp_vid;
      r_rsp_vid_vector <= w_rsp_vid_vector;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign cfg_done       = r_cfg_done;
  assign map_err        = r_map_err;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_mapped     = r_rsp_mapped;
  assign rsp_vid        = r_rsp_vid;
  assign rsp_vid_vector = r_rsp_vid_vector;

endmodule

// File: tb/tb_generic_pidtovid.sv
// Bench for generic_pidtovid: reference owner-table model feeds an expected-response queue.
module tb_generic_pidtovid;

  logic        clk;
  logic        reset_n;
  logic        cfg_load;
  logic [7:0]  cfg_fuse_map;
  logic [23:0] cfg_vid_map;
  logic        cfg_done;
  logic        map_err;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_pid;
  logic [7:0]  req_pid_vector;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_vid;
  logic        rsp_mapped;
  logic [7:0]  rsp_vid_vector;

  generic_pidtovid #(.NumHarts(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_load(cfg_load), .cfg_fuse_map(cfg_fuse_map), .cfg_vid_map(cfg_vid_map),
    .cfg_done(cfg_done), .map_err(map_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_pid(req_pid),
    .req_pid_vector(req_pid_vector),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vid(rsp_vid),
    .rsp_mapped(rsp_mapped), .rsp_vid_vector(rsp_vid_vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] vid;
    logic       mapped;
    logic [7:0] vec;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       m_fuse    [8];
  logic [2:0] m_vid     [8];
  logic [2:0] m_own     [8];
  logic       m_own_vld [8];
  logic       m_err;

  localparam logic [23:0] VM_IDENT = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] VM_PERM  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [23:0] VM_DUP   = {3'd7, 3'd6, 3'd5, 3'd4, 3'd2, 3'd3, 3'd2, 3'd0};

  task automatic model_load(input logic [7:0] f, input logic [23:0] vm);
    m_err = 1'b0;
    for (int v = 0; v < 8; v++) begin m_own_vld[v] = 1'b0; m_own[v] = '0; end
    for (int p = 0; p < 8; p++) begin
      m_fuse[p] = f[p];
      m_vid[p]  = vm[p*3 +: 3];
      if (f[p]) begin
        if (!m_own_vld[m_vid[p]]) begin
          m_own_vld[m_vid[p]] = 1'b1;
          m_own[m_vid[p]]     = 3'(p);
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  function automatic exp_t model_rsp(input logic [2:0] pid, input logic [7:0] vec);
    exp_t r;
    r.mapped = m_fuse[pid] && m_own_vld[m_vid[pid]] && (m_own[m_vid[pid]] == pid);
    r.vid    = r.mapped ? m_vid[pid] : 3'd0;
    for (int v = 0; v < 8; v++) r.vec[v] = m_own_vld[v] ? vec[m_own[v]] : 1'b0;
    return r;
  endfunction

  task automatic load_map(input string name, input logic [7:0] f, input logic [23:0] vm);
    int n;
    @(negedge clk);
    cfg_load = 1'b1; cfg_fuse_map = f; cfg_vid_map = vm;
    model_load(f, vm);
    @(negedge clk);
    cfg_load = 1'b0;
    n = 0;
    while (cfg_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (n != 9) begin n_fail++; $display("FAIL %s done_latency: got %0d cycles, want 9", name, n); end
    n_checks++;
    if (map_err !== m_err) begin n_fail++; $display("FAIL %s map_err: got %b, want %b", name, map_err, m_err); end
  endtask

  task automatic send_req(input string name, input logic [2:0] pid, input logic [7:0] vec);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_pid = pid; req_pid_vector = vec; rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s req_ready: got %b, want 1", name, req_ready); end
    q.push_back(model_rsp(pid, vec));
    @(negedge clk);
    req_valid = 1'b0;
    e = q.pop_front();
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL %s rsp_valid: got %b, want 1", name, rsp_valid); end
    n_checks++;
    if ({rsp_vid, rsp_mapped, rsp_vid_vector} !== {e.vid, e.mapped, e.vec})
    begin
      n_fail++;
      $display("FAIL %s rsp pid=%0d: got vid=%0d mapped=%b vec=%h, want vid=%0d mapped=%b vec=%h",
               name, pid, rsp_vid, rsp_mapped, rsp_vid_vector, e.vid, e.mapped, e.vec);
    end
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    #1;
    n_checks++;
    if ({cfg_done, map_err, req_ready, rsp_valid, rsp_mapped} !== 5'b0 || rsp_vid !== 3'd0 || rsp_vid_vector !== 8'h00)
    begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b err=%b rdy=%b vld=%b map=%b vid=%0d vec=%h, want all 0",
               cfg_done, map_err, req_ready, rsp_valid, rsp_mapped, rsp_vid, rsp_vid_vector);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b, want 0", req_ready); end
    req_valid = 1'b0;
  endtask

  task automatic test_identity();
    load_map("identity", 8'hFF, VM_IDENT);
    send_req("identity", 3'd5, 8'hA5);
    send_req("identity", 3'd0, 8'h3C);
  endtask

  task automatic test_permuted();
    load_map("permuted", 8'hFF, VM_PERM);
    send_req("permuted", 3'd2, 8'h01);
    send_req("permuted", 3'd7, 8'hC6);
  endtask

  task automatic test_partial_fuse();
    load_map("partial", 8'h0F, VM_IDENT);
    send_req("partial", 3'd6, 8'hF0);
    send_req("partial", 3'd2, 8'hFF);
  endtask

  task automatic test_duplicate();
    load_map("duplicate", 8'hFF, VM_DUP);
    send_req("duplicate", 3'd3, 8'h08);
    send_req("duplicate", 3'd1, 8'h0A);
    send_req("duplicate", 3'd2, 8'hFF);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_pid = 3'd4; req_pid_vector = 8'h5A; rsp_ready = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b, want 1", req_ready); end
    q.push_back(model_rsp(3'd4, 8'h5A));
    @(negedge clk);
    req_pid = 3'd1; req_pid_vector = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      e = q[0];
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready cyc%0d: got %b, want 0", i, req_ready); end
      n_checks++;
      if ({rsp_valid, rsp_vid, rsp_mapped, rsp_vid_vector} !== {1'b1, e.vid, e.mapped, e.vec})
      begin
        n_fail++;
        $display("FAIL bp_hold_rsp cyc%0d: got vld=%b vid=%0d map=%b vec=%h, want vld=1 vid=%0d map=%b vec=%h",
                 i, rsp_valid, rsp_vid, rsp_mapped, rsp_vid_vector, e.vid, e.mapped, e.vec);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b, want 1", req_ready); end
    void'(q.pop_front());
    q.push_back(model_rsp(3'd1, 8'hFF));
    @(negedge clk);
    req_valid = 1'b0;
    e = q.pop_front();
    n_checks++;
    if ({rsp_valid, rsp_vid, rsp_mapped, rsp_vid_vector} !== {1'b1, e.vid, e.mapped, e.vec})
    begin
      n_fail++;
      $display("FAIL bp_next_rsp: got vld=%b vid=%0d map=%b vec=%h, want vld=1 vid=%0d map=%b vec=%h",
               rsp_valid, rsp_vid, rsp_mapped, rsp_vid_vector, e.vid, e.mapped, e.vec);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got rsp_valid=%b, want 0", rsp_valid); end
  endtask

  task automatic test_restart();
    @(negedge clk);
    cfg_load = 1'b1; cfg_fuse_map = 8'hFF; cfg_vid_map = VM_IDENT;
    @(negedge clk);
    cfg_load = 1'b0;
    repeat (2) @(negedge clk);
    load_map("restart", 8'hFF, VM_PERM);
    send_req("restart", 3'd2, 8'h01);
  endtask

  task automatic test_reset_midscan();
    exp_t e;
    int   n;
    load_map("midscan_setup", 8'hFF, VM_DUP);
    @(negedge clk);
    req_valid = 1'b1; req_pid = 3'd1; req_pid_vector = 8'h0A; rsp_ready = 1'b0;
    q.push_back(model_rsp(3'd1, 8'h0A));
    @(negedge clk);
    req_valid = 1'b0;
    cfg_load  = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL load_blocks_ready: got %b, want 0", req_ready); end
    @(negedge clk);
    cfg_load = 1'b0;
    n = 0;
    repeat (4) @(negedge clk);
    e = q[0];
    n_checks++;
    if (map_err !== 1'b1) begin n_fail++; $display("FAIL midscan_err: got %b, want 1", map_err); end
    n_checks++;
    if ({rsp_valid, rsp_vid, rsp_mapped, rsp_vid_vector} !== {1'b1, e.vid, e.mapped, e.vec})
    begin
      n_fail++;
      $display("FAIL pending_across_load: got vld=%b vid=%0d map=%b vec=%h, want vld=1 vid=%0d map=%b vec=%h",
               rsp_valid, rsp_vid, rsp_mapped, rsp_vid_vector, e.vid, e.mapped, e.vec);
    end
    rsp_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    void'(q.pop_front());
    n_checks++;
    if ({cfg_done, map_err, req_ready, rsp_valid, rsp_mapped} !== 5'b0 || rsp_vid !== 3'd0 || rsp_vid_vector !== 8'h00)
    begin
      n_fail++;
      $display("FAIL midscan_reset: got done=%b err=%b rdy=%b vld=%b map=%b vid=%0d vec=%h, want all 0",
               cfg_done, map_err, req_ready, rsp_valid, rsp_mapped, rsp_vid, rsp_vid_vector);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if ({req_ready, cfg_done} !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle: got rdy=%b done=%b, want 0 0", req_ready, cfg_done); end
  endtask

  initial begin
    reset_n = 1'b0; cfg_load = 1'b0; cfg_fuse_map = '0; cfg_vid_map = '0;
    req_valid = 1'b0; req_pid = '0; req_pid_vector = '0; rsp_ready = 1'b1;
    test_reset();
    test_identity();
    test_permuted();
    test_partial_fuse();
    test_duplicate();
    test_back_to_back();
    test_restart();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
